keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Drives the column lines of the 4x4 calculator keypad and samples its row lines. Debounces a single key press and reports its matrix position as row_index/col_index with a one-cycle key_valid strobe. Sits directly upstream of the key decoder, which concatenates {row_index, col_index} into a key code. Those outputs are therefore registered and stable between presses.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before sampling and advancing; must be >= 4 to cover synchronizer latency.
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press and, separately, a release; must be >= 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
row_in  input  4  raw keypad rows, active-low, asynchronous, externally pulled up
col_out  output  4  column drive, active-low, exactly one bit low at all times
row_index  output  4  row number 0..3 of the last accepted key, zero-extended
col_index  output  2  column number 0..3 of the last accepted key
key_valid  output  1  one-cycle pulse per accepted press
key_held  output  1  high from the accept cycle until release is debounced

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high on rst.
- Reset values: col_out=4'b1110 (column 0), row_index=0, col_index=0, key_valid=0, key_held=0. Synchronizer flops = 4'hF. Counters = 0. State = SCAN.
- row_in passes through a 2-flop synchronizer. All decisions use the synchronized value rows_s. A row bit low means that key is pressed in the driven column.
- SCAN:
  - Dwell counter runs 0..SCAN_DIV-1. At the terminal count, rows_s is checked.
  - If any bit is low: capture the lowest-numbered low row (row 0 highest priority) and the current column, then go to DEBOUNCE. The column stays driven.
  - Otherwise: advance to the next column, wrapping 3->0, and clear the counter.
- DEBOUNCE:
  - Column stays held. The counter increments each cycle the captured row bit is low.
  - If that bit reads high: go back to SCAN, advance the column, no strobe.
  - When the count reaches DEBOUNCE_CYCLES-1 with the bit still low: go to PRESS.
- PRESS (one cycle):
  - key_valid=1, key_held=1.
  - row_index/col_index load the captured values on the same edge that raises key_valid.
  - Next state is RELEASE.
- RELEASE:
  - Column stays held. The counter increments while the captured row bit is high; any low sample clears it.
  - At DEBOUNCE_CYCLES-1: key_held=0, go to SCAN, advance the column.
  - No auto-repeat: a held key produces exactly one key_valid.
- row_index/col_index hold their value until the next PRESS; they never change on release or in SCAN.
- Multiple keys:
  - Same column: lowest row wins.
  - Other columns: ignored until release completes.
  - A different key in the same column during RELEASE is ignored; only the captured row bit is monitored.
- Reset mid-operation (any state): next edge restores all reset values. A pending press is dropped with no key_valid.
- Counter widths: $clog2 of the larger of SCAN_DIV and DEBOUNCE_CYCLES. Counters never wrap past terminal count.

Decomposition:
- Shared package keypad_pkg holds:
  - the state encoding (SCAN, DEBOUNCE, PRESS, RELEASE);
  - N_ROWS=4 and N_COLS=4;
  - COL_RESET=4'b1110.
- One sub-module, keypad_sync: a parameterized-width 2-flop synchronizer with reset value all-ones.

Test Plan:
(All with SCAN_DIV=4, DEBOUNCE_CYCLES=3.)
1. Reset, rows all high -> col_out steps 1110->1101->1011->0111->1110 every 4 cycles; key_valid, key_held stay 0; row_index=0, col_index=0.
2. Row 2 held low whenever column 1 is driven, for 50 cycles -> exactly one key_valid pulse with row_index=2, col_index=1 on that cycle; key_held=1 until the row is released plus 3 stable cycles; no repeat pulse.
3. Bounce: row 0 low for 2 synchronized cycles during column 3, then high -> no key_valid; col_out advances to 1110 and scanning resumes.
4. Rows 1 and 3 both low in column 2 -> single pulse, row_index=1, col_index=2.
5. Release glitch: after an accepted press, the row goes high 2 cycles, low 1 cycle, then high -> key_held drops only after 3 consecutive high cycles. A second press of the same key afterwards produces a second key_valid.
6. rst pulsed for one cycle during DEBOUNCE -> next cycle col_out=1110, key_valid=0, key_held=0, state SCAN; the aborted press never strobes.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix geometry, scan state
// encoding and small decode helpers.
package keypad_pkg;

    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;

    localparam logic [N_COLS-1:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESS    = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    // Row 0 has the highest priority when several rows read low.
    function automatic logic [1:0] first_low_row(input logic [N_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = '0;
        for (int i = N_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [N_COLS-1:0] col_drive(input logic [1:0] col);
        return ~(N_COLS'(1) << col);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key report seen by the downstream key decoder: position of the last
// accepted key plus its press strobe and held flag.
interface keypad_scanner_if;

    logic [3:0] row_index;
    logic [1:0] col_index;
    logic       key_valid;
    logic       key_held;

    modport master (
        output row_index,
        output col_index,
        output key_valid,
        output key_held
    );

    modport slave (
        input row_index,
        input col_index,
        input key_valid,
        input key_held
    );

endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous, active-low inputs. Resets to
// all-ones so an idle (pulled-up) line never looks active out of reset.
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: flops are written with <= so every stage samples the value from
    // before the edge; a blocking = here would collapse the two stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce. Reports one
// key_valid strobe per accepted press and holds the key position until the next.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_ROWS-1:0]   row_in,
    output logic [N_COLS-1:0]   col_out,
    keypad_scanner_if.master    key
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_ROWS-1:0] rows_s;

    scan_state_t      state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [1:0]       col_q,       col_d;
    logic [1:0]       cap_row_q,   cap_row_d;
    logic [1:0]       cap_col_q,   cap_col_d;
    logic [3:0]       row_index_q, row_index_d;
    logic [1:0]       col_index_q, col_index_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q,  key_held_d;
    logic             cap_bit;

    keypad_sync #(.WIDTH(N_ROWS)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (rows_s)
    );

    // Only the captured row is watched once a key is locked; other keys are ignored.
    assign cap_bit = rows_s[cap_row_q];

    // NOTE: every signal gets its hold value before the case so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        cap_row_d   = cap_row_q;
        cap_col_d   = cap_col_q;
        row_index_d = row_index_q;
        col_index_d = col_index_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        unique case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (rows_s != '1) begin
                        cap_row_d = first_low_row(rows_s);
                        cap_col_d = col_q;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DEBOUNCE: begin
                if (cap_bit) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = PRESS;
                    cnt_d       = '0;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    row_index_d = {2'b00, cap_row_q};
                    col_index_d = cap_col_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PRESS: begin
                state_d = RELEASE;
                cnt_d   = '0;
            end

            RELEASE: begin
                if (!cap_bit) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d    = SCAN;
                    col_d      = col_q + 2'd1;
                    cnt_d      = '0;
                    key_held_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            col_q       <= '0;
            cap_row_q   <= '0;
            cap_col_q   <= '0;
            row_index_q <= '0;
            col_index_q <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            cap_row_q   <= cap_row_d;
            cap_col_q   <= cap_col_d;
            row_index_q <= row_index_d;
            col_index_q <= col_index_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_out       = col_drive(col_q);
    assign key.row_index = row_index_q;
    assign key.col_index = col_index_q;
    assign key.key_valid = key_valid_q;
    assign key.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a simulated key matrix feeds row_in
// from col_out, and a run-length reference model predicts every output each cycle.
module tb_keypad_scanner;

    import keypad_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] row_in = 4'hF;
    logic [3:0] col_out;

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .row_in  (row_in),
        .col_out (col_out),
        .key     (kif)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    bit pressed [4][4];   // [row][col]

    // Reference model: column pointer, dwell count and run lengths of stable samples.
    logic [3:0] m_s1, m_s2;
    int         m_col, m_dwell, m_run, m_row, m_kcol;
    bit         m_locked, m_accepted, m_settle;
    bit         m_valid, m_held;
    int         m_ri, m_ci;
    int         m_pulses   = 0;
    int         dut_pulses = 0;
    logic [3:0] last_ri;
    logic [1:0] last_ci;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] keypad_rows();
        logic [3:0] rows;
        rows = 4'hF;
        for (int c = 0; c < 4; c++)
            if (col_out[c] === 1'b0)
                for (int r = 0; r < 4; r++)
                    if (pressed[r][c]) rows[r] = 1'b0;
        return rows;
    endfunction

    task automatic release_all();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pressed[r][c] = 1'b0;
    endtask

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF;
        m_col = 0; m_dwell = 0; m_run = 0; m_row = 0; m_kcol = 0;
        m_locked = 0; m_accepted = 0; m_settle = 0;
        m_valid = 0; m_held = 0; m_ri = 0; m_ci = 0;
    endtask

    task automatic model_step(input logic [3:0] pin, input logic r);
        logic [3:0] rs;
        if (r) begin
            model_reset();
            return;
        end
        rs = m_s2;
        m_s2 = m_s1;
        m_s1 = pin;
        m_valid = 0;
        if (!m_locked) begin
            if (m_dwell == SCAN_DIV - 1) begin
                m_dwell = 0;
                if (rs != 4'hF) begin
                    m_locked = 1;
                    m_run    = 0;
                    m_kcol   = m_col;
                    for (int i = 3; i >= 0; i--) if (!rs[i]) m_row = i;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end else begin
                m_dwell++;
            end
        end else if (!m_accepted) begin
            if (rs[m_row]) begin
                m_locked = 0;
                m_col    = (m_col + 1) % 4;
                m_dwell  = 0;
            end else if (m_run + 1 == DEB) begin
                m_accepted = 1; m_settle = 1;
                m_valid = 1; m_held = 1;
                m_ri = m_row; m_ci = m_kcol;
                m_pulses++;
            end else begin
                m_run++;
            end
        end else if (m_settle) begin
            m_settle = 0;
            m_run    = 0;
        end else begin
            if (!rs[m_row]) m_run = 0;
            else if (m_run + 1 == DEB) begin
                m_held = 0; m_locked = 0; m_accepted = 0;
                m_col = (m_col + 1) % 4;
                m_dwell = 0;
            end else begin
                m_run++;
            end
        end
    endtask

    task automatic tick();
        logic [3:0] exp_col;
        row_in = keypad_rows();
        @(posedge clk);
        model_step(row_in, rst);
        #1;
        if (kif.key_valid === 1'b1) begin
            dut_pulses++;
            last_ri = kif.row_index;
            last_ci = kif.col_index;
        end
        exp_col = ~(4'b0001 << m_col);
        check("col_out",   8'(col_out),       8'(exp_col));
        check("key_valid", 8'(kif.key_valid), 8'(m_valid));
        check("key_held",  8'(kif.key_held),  8'(m_held));
        check("row_index", 8'(kif.row_index), 8'(m_ri));
        check("col_index", 8'(kif.col_index), 8'(m_ci));
    endtask

    task automatic wait_held_low(input string tag, input int budget);
        int k = 0;
        while (kif.key_held !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        check(tag, 8'(kif.key_held), 8'd0);
    endtask

    task automatic wait_col(input string tag, input logic [3:0] target, input int budget);
        int k = 0;
        while (col_out !== target && k < budget) begin
            tick();
            k++;
        end
        check(tag, 8'(col_out), 8'(target));
    endtask

    task automatic wait_pulse(input string tag, input int base, input int budget);
        int k = 0;
        while (dut_pulses == base && k < budget) begin
            tick();
            k++;
        end
        check(tag, 8'(dut_pulses - base), 8'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         base;
        int         k;
        logic [3:0] exp_col;

        release_all();
        model_reset();

        // Reset and idle scan rotation
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_col_out",   8'(col_out),       8'h0E);
        check("rst_key_valid", 8'(kif.key_valid), 8'h00);
        check("rst_key_held",  8'(kif.key_held),  8'h00);
        check("rst_row_index", 8'(kif.row_index), 8'h00);
        check("rst_col_index", 8'(kif.col_index), 8'h00);
        for (int i = 1; i <= 8; i++) begin
            repeat (SCAN_DIV) tick();
            exp_col = ~(4'b0001 << (i % 4));
            check("idle_rotation", 8'(col_out), 8'(exp_col));
        end
        check("idle_no_pulse", 8'(dut_pulses), 8'd0);

        // Single key row 2 / column 1 held for 50 cycles
        base = dut_pulses;
        pressed[2][1] = 1'b1;
        repeat (50) tick();
        check("hold_one_pulse", 8'(dut_pulses - base), 8'd1);
        check("hold_row_index", 8'(last_ri), 8'd2);
        check("hold_col_index", 8'(last_ci), 8'd1);
        check("hold_key_held",  8'(kif.key_held), 8'd1);
        release_all();
        wait_held_low("hold_release", 20);
        repeat (4) tick();
        check("hold_no_repeat", 8'(dut_pulses - base), 8'd1);

        // Bounce: two synchronized low samples in column 3, then high
        base = dut_pulses;
        wait_col("bounce_wait_c2", 4'b1011, 40);
        wait_col("bounce_wait_c3", 4'b0111, 40);
        tick();
        pressed[0][3] = 1'b1;
        tick();
        tick();
        release_all();
        tick();
        tick();
        check("bounce_col_held", 8'(col_out), 8'h07);
        tick();
        check("bounce_col_adv",  8'(col_out), 8'h0E);
        repeat (8) tick();
        check("bounce_no_pulse", 8'(dut_pulses - base), 8'd0);

        // Two keys in column 2: lowest row wins
        base = dut_pulses;
        pressed[1][2] = 1'b1;
        pressed[3][2] = 1'b1;
        repeat (40) tick();
        check("multi_one_pulse", 8'(dut_pulses - base), 8'd1);
        check("multi_row_index", 8'(last_ri), 8'd1);
        check("multi_col_index", 8'(last_ci), 8'd2);
        release_all();
        wait_held_low("multi_release", 20);

        // Release glitch: high 2, low 1, then high
        base = dut_pulses;
        pressed[0][0] = 1'b1;
        wait_pulse("glitch_first_press", base, 40);
        repeat (4) tick();
        release_all();
        tick();
        tick();
        pressed[0][0] = 1'b1;
        tick();
        release_all();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("glitch_still_held", 8'(kif.key_held), 8'd1);
        end
        tick();
        check("glitch_held_drop", 8'(kif.key_held), 8'd0);
        base = dut_pulses;
        pressed[0][0] = 1'b1;
        wait_pulse("glitch_second_press", base, 40);
        check("second_row_index", 8'(last_ri), 8'd0);
        check("second_col_index", 8'(last_ci), 8'd0);
        release_all();
        wait_held_low("second_release", 20);

        // Reset pulsed while a press is debouncing
        base = dut_pulses;
        pressed[3][1] = 1'b1;
        k = 0;
        while (!(m_locked && !m_accepted) && k < 40) begin
            tick();
            k++;
        end
        check("abort_reached_debounce", 8'(m_locked && !m_accepted), 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        release_all();
        check("abort_col_out",   8'(col_out),       8'h0E);
        check("abort_key_valid", 8'(kif.key_valid), 8'd0);
        check("abort_key_held",  8'(kif.key_held),  8'd0);
        repeat (20) tick();
        check("abort_no_pulse", 8'(dut_pulses - base), 8'd0);

        // Randomized presses with chatter, checked cycle by cycle against the model
        for (int it = 0; it < 16; it++) begin
            int r, c, hold;
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            hold = $urandom_range(0, 45);
            pressed[r][c] = 1'b1;
            if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 3)][c] = 1'b1;
            for (int t = 0; t < hold; t++) begin
                if ($urandom_range(0, 7) == 0) pressed[r][c] = !pressed[r][c];
                tick();
            end
            release_all();
            repeat ($urandom_range(0, 25)) tick();
        end
        release_all();
        repeat (20) tick();
        check("random_pulse_count", 8'(dut_pulses), 8'(m_pulses));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
